// File: rtl/branch_hazard_ctrl_pkg.sv
// branch_hazard_ctrl_pkg: shared pipeline constants, FSM encoding and load-use compare
package branch_hazard_ctrl_pkg;
  localparam int REG_W = 5;
  localparam int PEN_W = 3;
  localparam logic [7:0] IDEX_NOP = 8'h00;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SQUASH = 2'd1,
    STALL  = 2'd2
  } state_t;
  // r0 is hardwired zero, so a load targeting it never creates a dependency
  function automatic logic load_use(
    input logic             mr,
    input logic [REG_W-1:0] ert,
    input logic [REG_W-1:0] rs,
    input logic [REG_W-1:0] rt,
    input logic             ur
  );
    return mr & (ert != '0) & ((ert == rs) | (ur & (ert == rt)));
  endfunction
endpackage

// File: rtl/branch_hazard_ctrl_sat_counter.sv
// sat_counter: saturating up-counter with asynchronous active-low clear
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clrn,
  input  logic         inc,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) q <= '0;
    else if (inc && !(&q)) q <= q + 1'b1;
endmodule

// File: rtl/branch_hazard_ctrl.sv
// branch_hazard_ctrl: redirects on taken branches/jumps, squashes wrong-path work,
// inserts load-use stalls and keeps saturating event counters
module branch_hazard_ctrl
  import branch_hazard_ctrl_pkg::*;
#(
  parameter int PC_W       = 32,
  parameter int BR_PENALTY = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             ex_branch,
  input  logic             ex_cond,
  input  logic             ex_jump,
  input  logic [PC_W-1:0]  ex_target,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  output logic             pc_sel,
  output logic [PC_W-1:0]  pc_target,
  output logic             pc_wen,
  output logic             ifid_wen,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             busy,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [CNT_W-1:0] squash_cnt,
  output logic [CNT_W-1:0] stall_cnt
);
  state_t           state;
  logic [PEN_W-1:0] pen;
  logic             take, luse, sq, tk, lu;
  // EX holds bubbles during SQUASH, so neither redirects nor stalls can fire there
  always_comb begin
    take = ex_jump | (ex_branch & ex_cond);
    luse = load_use(ex_memread, ex_rt, id_rs, id_rt, id_uses_rt);
    sq   = state == SQUASH;
    tk   = !sq & take;
    lu   = (state == IDLE) & !take & luse;
  end
  assign pc_sel     = tk;
  assign pc_target  = ex_target;
  assign pc_wen     = !lu;
  assign ifid_wen   = !lu;
  assign ifid_flush = tk;
  assign idex_flush = tk | lu | sq;
  assign busy       = state != IDLE;
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      state <= IDLE;
      pen   <= '0;
    end else if (sq) begin
      pen   <= pen - 1'b1;
      state <= pen == PEN_W'(1) ? IDLE : SQUASH;
    end else if (tk) begin
      pen   <= PEN_W'(BR_PENALTY - 1);
      state <= BR_PENALTY > 1 ? SQUASH : IDLE;
    end else begin
      state <= lu ? STALL : IDLE;
    end
  sat_counter #(.W(CNT_W)) u_redirect (.clk(clk), .clrn(clrn), .inc(tk),         .q(redirect_cnt));
  sat_counter #(.W(CNT_W)) u_squash   (.clk(clk), .clrn(clrn), .inc(idex_flush), .q(squash_cnt));
  sat_counter #(.W(CNT_W)) u_stall    (.clk(clk), .clrn(clrn), .inc(lu),         .q(stall_cnt));
endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// tb_branch_hazard_ctrl: scoreboard bench; expected control words queued at drive time,
// popped and compared mid-cycle, counters compared against bench-side tallies
module tb_branch_hazard_ctrl;
  logic        clk, clrn;
  logic        ex_branch, ex_cond, ex_jump, ex_memread, id_uses_rt;
  logic [31:0] ex_target;
  logic [4:0]  ex_rt, id_rs, id_rt;
  logic        pc_sel, pc_wen, ifid_wen, ifid_flush, idex_flush, busy;
  logic [31:0] pc_target;
  logic [15:0] redirect_cnt, squash_cnt, stall_cnt;
  logic        s_sel, s_pcw, s_ifw, s_ifl, s_idl, s_busy;
  logic [31:0] s_tgt;
  logic [3:0]  s_red, s_sq, s_st;
  int errors = 0, checks = 0;
  int exp_red, exp_sq, exp_st;
  typedef struct packed {
    logic        sel;
    logic [31:0] tgt;
    logic        pcw;
    logic        ifw;
    logic        ifl;
    logic        idl;
    logic        bsy;
  } ctrl_t;
  ctrl_t sb[$];
  ctrl_t e, o;
  branch_hazard_ctrl dut (
    .clk(clk), .clrn(clrn), .ex_branch(ex_branch), .ex_cond(ex_cond), .ex_jump(ex_jump),
    .ex_target(ex_target), .ex_memread(ex_memread), .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .pc_sel(pc_sel), .pc_target(pc_target), .pc_wen(pc_wen),
    .ifid_wen(ifid_wen), .ifid_flush(ifid_flush), .idex_flush(idex_flush), .busy(busy),
    .redirect_cnt(redirect_cnt), .squash_cnt(squash_cnt), .stall_cnt(stall_cnt)
  );
  branch_hazard_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .clrn(clrn), .ex_branch(ex_branch), .ex_cond(ex_cond), .ex_jump(ex_jump),
    .ex_target(ex_target), .ex_memread(ex_memread), .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .pc_sel(s_sel), .pc_target(s_tgt), .pc_wen(s_pcw),
    .ifid_wen(s_ifw), .ifid_flush(s_ifl), .idex_flush(s_idl), .busy(s_busy),
    .redirect_cnt(s_red), .squash_cnt(s_sq), .stall_cnt(s_st)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  function automatic ctrl_t obs();
    return {pc_sel, pc_target, pc_wen, ifid_wen, ifid_flush, idex_flush, busy};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic b, c, j, input logic [31:0] t, input logic mr,
                       input logic [4:0] ert, irs, irt, input logic ur);
    ex_branch = b; ex_cond = c; ex_jump = j; ex_target = t;
    ex_memread = mr; ex_rt = ert; id_rs = irs; id_rt = irt; id_uses_rt = ur;
  endtask
  task automatic idle();
    drive(0, 0, 0, $urandom, 0, 5'd0, 5'd0, 5'd0, 0);
  endtask
  task automatic push(input logic sel, pcw, ifw, ifl, idl, bsy);
    sb.push_back({sel, ex_target, pcw, ifw, ifl, idl, bsy});
  endtask
  task automatic test_reset();
    clrn = 1;
    for (int i = 0; i < 6; i++) begin
      drive($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
      tick();
    end
    drive(0, 0, 1, 32'h100, 0, 5'd0, 5'd0, 5'd0, 0);
    tick();
    #2 clrn = 0;
    #1;
    checks++;
    if ({busy, s_busy, redirect_cnt, squash_cnt, stall_cnt, s_red, s_sq, s_st} !== '0) begin
      errors++;
      $display("FAIL reset_async busy=%b/%b cnt=%0d/%0d/%0d cnt4=%0d/%0d/%0d required all 0",
               busy, s_busy, redirect_cnt, squash_cnt, stall_cnt, s_red, s_sq, s_st);
    end
    drive($urandom, $urandom, 1, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
    tick();
    checks++;
    if ({busy, redirect_cnt, squash_cnt, stall_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_held busy=%b cnt=%0d/%0d/%0d required all 0", busy, redirect_cnt, squash_cnt, stall_cnt);
    end
    idle();
    #2 clrn = 1;
    exp_red = 0; exp_sq = 0; exp_st = 0;
    push(0, 1, 1, 0, 0, 0);
    @(negedge clk);
    e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL reset_release got=%h required=%h", o, e); end
    tick();
  endtask
  task automatic check_counts(input string name);
    checks++;
    if ({redirect_cnt, squash_cnt, stall_cnt} !== {16'(exp_red), 16'(exp_sq), 16'(exp_st)}) begin
      errors++;
      $display("FAIL %s counters got=%0d/%0d/%0d required=%0d/%0d/%0d", name,
               redirect_cnt, squash_cnt, stall_cnt, exp_red, exp_sq, exp_st);
    end
  endtask
  task automatic test_taken_branch();
    drive(1, 1, 0, 32'h40, 0, 5'd0, 5'd0, 5'd0, 0);
    push(1, 1, 1, 1, 1, 0);
    @(negedge clk);
    e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL taken_T got=%h required=%h", o, e); end
    tick(); exp_red++; exp_sq++;
    drive(0, 0, 0, 32'h40, 0, 5'd0, 5'd0, 5'd0, 0);
    push(0, 1, 1, 0, 1, 1);
    @(negedge clk);
    e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL taken_T1 got=%h required=%h", o, e); end
    tick(); exp_sq++;
    push(0, 1, 1, 0, 0, 0);
    @(negedge clk);
    e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL taken_T2 got=%h required=%h", o, e); end
    check_counts("taken");
    tick();
  endtask
  task automatic test_not_taken();
    drive(1, 0, 0, 32'h80, 0, 5'd0, 5'd0, 5'd0, 0);
    push(0, 1, 1, 0, 0, 0);
    @(negedge clk);
    e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL not_taken got=%h required=%h", o, e); end
    tick();
    idle();
    check_counts("not_taken");
  endtask
  task automatic test_load_use();
    drive(0, 0, 0, $urandom, 1, 5'd5, 5'd5, 5'd0, 0);
    push(0, 0, 0, 0, 1, 0);
    @(negedge clk);
    e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL luse_rs got=%h required=%h", o, e); end
    tick(); exp_st++; exp_sq++;
    idle();
    push(0, 1, 1, 0, 0, 1);
    @(negedge clk);
    e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL luse_stall_state got=%h required=%h", o, e); end
    tick();
    check_counts("luse_rs");
    drive(0, 0, 0, $urandom, 1, 5'd0, 5'd0, 5'd0, 1);
    push(0, 1, 1, 0, 0, 0);
    @(negedge clk);
    e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL luse_r0 got=%h required=%h", o, e); end
    tick();
    drive(0, 0, 0, $urandom, 1, 5'd7, 5'd3, 5'd7, 1);
    push(0, 0, 0, 0, 1, 0);
    @(negedge clk);
    e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL luse_rt got=%h required=%h", o, e); end
    tick(); exp_st++; exp_sq++;
    drive(0, 0, 0, $urandom, 1, 5'd7, 5'd3, 5'd7, 0);
    push(0, 1, 1, 0, 0, 1);
    @(negedge clk);
    e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL luse_after_stall got=%h required=%h", o, e); end
    tick();
    push(0, 1, 1, 0, 0, 0);
    @(negedge clk);
    e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL luse_rt_unused got=%h required=%h", o, e); end
    tick();
    idle();
    check_counts("luse");
  endtask
  task automatic test_back_to_back();
    drive(0, 0, 1, $urandom, 1, 5'd5, 5'd5, 5'd0, 0);
    push(1, 1, 1, 1, 1, 0);
    @(negedge clk);
    e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL take_and_luse got=%h required=%h", o, e); end
    tick(); exp_red++; exp_sq++;
    drive(1, 1, 1, $urandom, 1, 5'd5, 5'd5, 5'd0, 0);
    push(0, 1, 1, 0, 1, 1);
    @(negedge clk);
    e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL jump_in_squash got=%h required=%h", o, e); end
    tick(); exp_sq++;
    idle();
    push(0, 1, 1, 0, 0, 0);
    @(negedge clk);
    e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL squash_exit got=%h required=%h", o, e); end
    check_counts("take_luse");
    tick();
    drive(0, 0, 0, $urandom, 1, 5'd9, 5'd9, 5'd0, 0);
    push(0, 0, 0, 0, 1, 0);
    @(negedge clk);
    e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL stall_then_jump_a got=%h required=%h", o, e); end
    tick(); exp_st++; exp_sq++;
    drive(0, 0, 1, $urandom, 0, 5'd0, 5'd0, 5'd0, 0);
    push(1, 1, 1, 1, 1, 1);
    @(negedge clk);
    e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL stall_then_jump_b got=%h required=%h", o, e); end
    tick(); exp_red++; exp_sq++;
    idle();
    push(0, 1, 1, 0, 1, 1);
    @(negedge clk);
    e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL stall_then_jump_c got=%h required=%h", o, e); end
    tick(); exp_sq++;
    push(0, 1, 1, 0, 0, 0);
    @(negedge clk);
    e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL stall_then_jump_d got=%h required=%h", o, e); end
    check_counts("stall_jump");
    tick();
  endtask
  task automatic test_saturation();
    idle();
    clrn = 0;
    tick();
    clrn = 1;
    exp_red = 0; exp_sq = 0; exp_st = 0;
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 1, $urandom, 0, 5'd0, 5'd0, 5'd0, 0);
      push(1, 1, 1, 1, 1, 0);
      @(negedge clk);
      e = sb.pop_front(); o = obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL sat_jump%0d got=%h required=%h", i, o, e); end
      tick(); exp_red++; exp_sq++;
      idle();
      push(0, 1, 1, 0, 1, 1);
      @(negedge clk);
      e = sb.pop_front(); o = obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL sat_squash%0d got=%h required=%h", i, o, e); end
      tick(); exp_sq++;
    end
    check_counts("sat_wide");
    checks++;
    if ({s_red, s_sq, s_st} !== {4'd15, 4'd15, 4'd0}) begin
      errors++;
      $display("FAIL sat_narrow got=%0d/%0d/%0d required=15/15/0", s_red, s_sq, s_st);
    end
  endtask
  initial begin
    clrn = 0;
    idle();
    #12;
    test_reset();
    test_taken_branch();
    test_not_taken();
    test_load_use();
    test_back_to_back();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
